booth_pp_accumulator: RTL and testbench
=======================================

Name: booth_pp_accumulator

Overview:
- Sequential consumer of radix-4 Booth partial-product rows; the summing end of the multiplier datapath.
- The upstream row generator emits W+1-bit rows with an inverted-MSB sign-extension encoding and a separate +1 negate bit, one row per handshake.
- This block aligns each row, adds it into a 2W-bit accumulator with a constant correction, and presents the signed×signed product with a valid/ready handshake.

Parameters:
- WIDTH, 64, operand width W. Must be even and ≥4.
- NROWS, WIDTH/2, number of Booth rows per product (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort. Discards the partial sum and returns to a fresh accumulation.
- in_valid  in  1  row handshake valid.
- in_ready  out  1  row handshake ready.
- in_pp  in  WIDTH+1  partial-product row, inverted-MSB encoded.
- in_sign  in  1  negate carry-in for this row, weight 4^idx.
- row_idx  out  clog2(NROWS)  index of the next row expected. The producer uses it to select multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
- out_valid  out  1  product valid.
- out_ready  in  1  product accepted.
- product  out  2*WIDTH  signed product, modulo 2^(2W).

Behaviour:
- Row arithmetic:
  - Each row satisfies in_pp + in_sign = t_i + 2^W, where t_i ∈ {0, ±A, ±2A}.
  - Product = Σ(in_pp + in_sign)·4^i − CORR, where CORR = 2^W·(4^NROWS − 1)/3.
  - All arithmetic is unsigned modulo 2^(2W).
  - Rows are zero-extended to 2W bits, then shifted left by 2·row_idx. in_sign is added at bit 2·row_idx.
- Accumulator init:
  - acc = (−CORR) mod 2^(2W) on reset, on flush, and on product handoff.
  - Example: W=8 gives CORR = 0x5500 and init = 0xAB00.
- FSM states: ACC and DONE.
  - ACC: in_ready=1, out_valid=0.
    - On in_valid: acc += aligned row + sign, and row_idx increments.
    - When the accepted row has row_idx == NROWS−1: product <= final sum (registered), go to DONE, row_idx wraps to 0.
  - DONE: in_ready=0, out_valid=1, product held stable.
    - On out_ready: acc reloads init, go to ACC.
    - in_valid in DONE is ignored; no row is consumed.
- Latency and throughput:
  - out_valid rises the cycle after the last row is accepted.
  - Minimum initiation interval is NROWS+1 cycles; handoff and the first row cannot share a cycle.
- Reset (asynchronous, any time including mid-product):
  - state=ACC, row_idx=0, acc=init, product=0, out_valid=0, in_ready=1.
- flush (synchronous, priority over everything except rst):
  - Same values as reset, except product keeps its old value.
  - out_valid drops. A product pending in DONE is discarded.
- No stalls inside ACC other than absent in_valid. There is no per-row timeout.

Decomposition:
- Shared multiplier package:
  - NROWS derivation function.
  - CORR constant function of WIDTH.
  - Booth code localparams (000..111) shared with the row generator.
  - State enum {ACC, DONE}.
- Sub-module booth_pp_align (combinational): takes in_pp, in_sign and row_idx; produces the 2W-bit aligned addend and the sign-injected carry word.
- The accumulator, counter and FSM stay in the top.

Test Plan:
All cases use WIDTH=8.
- A=3, B=5:
  - Stimulus: rows 0x103/0, 0x103/0, 0x100/0, 0x100/0, out_ready=1.
  - Expected: out_valid the cycle after row 3; product = 0x000F; returns to ACC; row_idx = 0.
- A=−1, B=−1:
  - Stimulus: rows 0x100/1, 0x100/0, 0x100/0, 0x100/0.
  - Expected: product = 0x0001.
- A=−128, B=−128:
  - Stimulus: rows 0x100/0 ×3, then 0x1FF/1 at row 3.
  - Expected: product = 0x4000.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after completion, with in_valid=1 throughout.
  - Expected: in_ready=0, product stable at 0x000F, no row consumed.
  - Then: out_ready=1 for one cycle gives out_valid=0 next cycle and accumulation restarts with row_idx = 0.
- Flush:
  - Stimulus: flush after 2 rows, then feed the full A=3, B=5 sequence.
  - Expected: product = 0x000F, with no contribution from the aborted rows.
- Async reset:
  - Stimulus: assert rst mid-cycle during DONE.
  - Expected: out_valid=0 and product=0 immediately, without waiting for a clock edge; row_idx = 0; the next full sequence yields the correct product.

Source files
------------

// File: rtl/booth_pp_accumulator_pkg.sv
// +--------------------------------------------------------------------------+
// | booth_pp_accumulator_pkg: shared radix-4 Booth multiplier definitions     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package booth_pp_accumulator_pkg;

  localparam int unsigned CORR_MAX_W = 256;

  // Booth codes {b[2i+1], b[2i], b[2i-1]}, shared with the row generator
  localparam logic [2:0] BOOTH_Z0 = 3'b000;
  localparam logic [2:0] BOOTH_P1A = 3'b001;
  localparam logic [2:0] BOOTH_P1B = 3'b010;
  localparam logic [2:0] BOOTH_P2 = 3'b011;
  localparam logic [2:0] BOOTH_M2 = 3'b100;
  localparam logic [2:0] BOOTH_M1A = 3'b101;
  localparam logic [2:0] BOOTH_M1B = 3'b110;
  localparam logic [2:0] BOOTH_Z1 = 3'b111;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  function automatic int unsigned nrows_f(input int unsigned w);
    return w / 2;
  endfunction

  // Sum of the 2^W sign-extension offsets of every row: 2^W * (4^NROWS-1)/3
  function automatic logic [CORR_MAX_W-1:0] corr_f(input int unsigned w);
    logic [CORR_MAX_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < w / 2; k++) begin
      r = r | (CORR_MAX_W'(1) << (w + 2 * k));
    end
    return r;
  endfunction

  function automatic int booth_digit_f(input logic [2:0] code);
    int d;
    d = 0;
    case (code)
      BOOTH_Z0, BOOTH_Z1:   d = 0;
      BOOTH_P1A, BOOTH_P1B: d = 1;
      BOOTH_P2:             d = 2;
      BOOTH_M2:             d = -2;
      BOOTH_M1A, BOOTH_M1B: d = -1;
      default:              d = 0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_pp_align.sv
// +--------------------------------------------------------------------------+
// | booth_pp_align: places one Booth row and its negate bit at weight 4^idx   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module booth_pp_align #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH:0]       pp_i,
  input  logic                 sign_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [2*WIDTH-1:0]   addend_o,
  output logic [2*WIDTH-1:0]   carry_o
);

  logic [IDX_W:0] shamt;

  assign shamt    = {idx_i, 1'b0};
  assign addend_o = {{(WIDTH-1){1'b0}}, pp_i} << shamt;
  assign carry_o  = {{(2*WIDTH-1){1'b0}}, sign_i} << shamt;

endmodule

`default_nettype wire

// File: rtl/booth_pp_accumulator.sv
// +--------------------------------------------------------------------------+
// | booth_pp_accumulator: sums radix-4 Booth rows into a signed 2W product   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module booth_pp_accumulator
  import booth_pp_accumulator_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int NROWS = int'(nrows_f(WIDTH)),
  localparam int IDX_W = $clog2(NROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_pp,
  input  logic                 in_sign,
  output logic [IDX_W-1:0]     row_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CORR_MAX_W-1:0] CORR_FULL = corr_f(WIDTH);
  localparam logic [2*WIDTH-1:0]    CORR      = CORR_FULL[2*WIDTH-1:0];
  localparam logic [2*WIDTH-1:0]    ACC_INIT  = -CORR;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NROWS - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   carry;

  booth_pp_align #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_align (
    .pp_i     (in_pp),
    .sign_i   (in_sign),
    .idx_i    (idx_q),
    .addend_o (addend),
    .carry_o  (carry)
  );

  assign acc_d = acc_q + addend + carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      idx_q       <= '0;
      acc_q       <= ACC_INIT;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // Abort keeps the last product visible but withdraws its valid
      state_q     <= ST_ACC;
      idx_q       <= '0;
      acc_q       <= ACC_INIT;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            if (idx_q == LAST_IDX) begin
              product_q   <= acc_d;
              idx_q       <= '0;
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc_q       <= ACC_INIT;
            state_q     <= ST_ACC;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          idx_q       <= '0;
          acc_q       <= ACC_INIT;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign row_idx   = idx_q;
  assign product   = product_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_pp_accumulator.sv
// +--------------------------------------------------------------------------+
// | tb_booth_pp_accumulator: WIDTH=8 vectors, handshake and abort sequences  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_booth_pp_accumulator;

  localparam int W = 8;

  typedef struct {
    logic [3:0][8:0] pp;
    logic [3:0]      sg;
    logic [15:0]     exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   in_pp;
  logic         in_sign;
  logic [1:0]   row_idx;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[3];

  booth_pp_accumulator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pp     (in_pp),
    .in_sign   (in_sign),
    .row_idx   (row_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0][8:0] pp, input logic [3:0] sg, input logic [15:0] exp);
    exp_q.push_back(exp);
    for (int i = 0; i < 4; i++) begin
      chk("row_idx", 32'(row_idx), i);
      chk("in_ready_acc", 32'(in_ready), 1);
      chk("out_valid_acc", 32'(out_valid), 0);
      in_valid = 1'b1;
      in_pp    = pp[i];
      in_sign  = sg[i];
      tick();
      in_valid = 1'b0;
    end
    chk("out_valid_rise", 32'(out_valid), 1);
    chk("in_ready_done", 32'(in_ready), 0);
    chk("row_idx_wrap", 32'(row_idx), 0);
  endtask

  task automatic drain;
    logic [15:0] e;
    chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    chk("product", 32'(product), 32'(e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 0);
    chk("in_ready_back", 32'(in_ready), 1);
    chk("row_idx_restart", 32'(row_idx), 0);
  endtask

  // Independent Booth recoder: row value + negate bit = digit*A + 2^W
  task automatic booth_rows(input int a, input int b,
                            output logic [3:0][8:0] pp, output logic [3:0] sg);
    logic [7:0] bb;
    int d, t, v, bm1;
    bb = 8'(b);
    for (int i = 0; i < 4; i++) begin
      bm1 = (i == 0) ? 0 : int'(bb[2*i-1]);
      d = -2 * int'(bb[2*i+1]) + int'(bb[2*i]) + bm1;
      t = d * a;
      v = t + 256;
      if (v == 512) begin
        pp[i] = 9'h1FF; sg[i] = 1'b1;
      end else if (t < 0 && v >= 1) begin
        pp[i] = 9'(v - 1); sg[i] = 1'b1;
      end else begin
        pp[i] = 9'(v); sg[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [3:0][8:0] rpp;
    logic [3:0]      rsg;
    int a, b;

    vecs[0].pp = {9'h100, 9'h100, 9'h103, 9'h103}; vecs[0].sg = 4'b0000; vecs[0].exp = 16'h000F;
    vecs[1].pp = {9'h100, 9'h100, 9'h100, 9'h100}; vecs[1].sg = 4'b0001; vecs[1].exp = 16'h0001;
    vecs[2].pp = {9'h1FF, 9'h100, 9'h100, 9'h100}; vecs[2].sg = 4'b1000; vecs[2].exp = 16'h4000;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pp = '0; in_sign = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_product", 32'(product), 0);
    chk("rst_row_idx", 32'(row_idx), 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      feed(vecs[v].pp, vecs[v].sg, vecs[v].exp);
      drain();
    end

    // Backpressure: DONE holds for 5 cycles while rows are offered
    feed(vecs[0].pp, vecs[0].sg, vecs[0].exp);
    in_valid = 1'b1; in_pp = 9'h1FF; in_sign = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_product", 32'(product), 32'h000F);
      chk("bp_row_idx", 32'(row_idx), 0);
    end
    in_valid = 1'b0;
    drain();
    feed(vecs[1].pp, vecs[1].sg, vecs[1].exp);
    drain();

    // Flush after two rows, then a clean product
    in_valid = 1'b1; in_pp = 9'h1FF; in_sign = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    chk("pre_flush_idx", 32'(row_idx), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_row_idx", 32'(row_idx), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    feed(vecs[0].pp, vecs[0].sg, vecs[0].exp);
    drain();

    // Flush while a product is pending: valid drops, value kept
    feed(vecs[2].pp, vecs[2].sg, vecs[2].exp);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(exp_q.pop_front());
    chk("flush_done_valid", 32'(out_valid), 0);
    chk("flush_done_product", 32'(product), 32'h4000);
    chk("flush_done_ready", 32'(in_ready), 1);
    feed(vecs[0].pp, vecs[0].sg, vecs[0].exp);
    drain();

    // Asynchronous reset mid-cycle in DONE
    feed(vecs[1].pp, vecs[1].sg, vecs[1].exp);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_product", 32'(product), 0);
    chk("arst_row_idx", 32'(row_idx), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    void'(exp_q.pop_front());
    tick();
    feed(vecs[0].pp, vecs[0].sg, vecs[0].exp);
    drain();

    // Random operands through an independent Booth recoder
    for (int n = 0; n < 8; n++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      if (n == 0) begin a = 127; b = -128; end
      if (n == 1) begin a = -128; b = 127; end
      booth_rows(a, b, rpp, rsg);
      feed(rpp, rsg, 16'(a * b));
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
